// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming (7,4) serial transmit arbiter.
//   CW_W / DATA_W : codeword and nibble widths
//   MAX_REQ       : widest requester count supported (index width IDX_W)
//   state_t       : transmit FSM states
package hamming_pkg;

  localparam int unsigned CW_W    = 7;
  localparam int unsigned DATA_W  = 4;
  localparam int unsigned MAX_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/hamming_tx_arbiter_if.sv
// Requester/transmit bundle between the requester logic and hamming_tx_arbiter.
//   req_valid/req_data/err_pos : driven by requesters (master)
//   req_ready, tx_bit, tx_frame, tx_owner, busy : driven by the arbiter (slave)
// err_pos exists only when ERR_INJECT_EN is defined.
interface hamming_tx_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  import hamming_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [DATA_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   tx_bit;
  logic                   tx_frame;
  logic [IDX_W-1:0]       tx_owner;
  logic                   busy;
`ifdef ERR_INJECT_EN
  logic [2:0]             err_pos;
`endif

  modport master (
`ifdef ERR_INJECT_EN
    output err_pos,
`endif
    output req_valid, req_data,
    input  req_ready, tx_bit, tx_frame, tx_owner, busy
  );

  modport slave (
`ifdef ERR_INJECT_EN
    input  err_pos,
`endif
    input  req_valid, req_data,
    output req_ready, tx_bit, tx_frame, tx_owner, busy
  );

endinterface

// File: rtl/hamming_encoder.sv
// Purely combinational Hamming (7,4) encoder.
//   data   : nibble d3..d0
//   code_c : codeword {d3,d2,d1,p4,d0,p2,p1}, bit 0 = p1
module hamming_encoder
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CW_W-1:0]   code_c
);

  logic p1, p2, p4;

  always_comb begin
    p1     = data[0] ^ data[1] ^ data[3];
    p2     = data[0] ^ data[2] ^ data[3];
    p4     = data[1] ^ data[2] ^ data[3];
    code_c = {data[3], data[2], data[1], p4, data[0], p2, p1};
  end

endmodule

// File: rtl/hamming_tx_arbiter.sv
// Round-robin arbiter sharing one Hamming (7,4) encoder among NREQ nibble
// requesters; the granted codeword is serialised LSB-first on tx_bit with
// each bit held BIT_DIV clocks and framed by tx_frame.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of hamming_tx_arbiter_if (handshake + serial out)
// Optional: define ERR_INJECT_EN to add bus.err_pos, which flips codeword
// bit err_pos-1 (1..7) at capture for decoder bring-up.
module hamming_tx_arbiter
  import hamming_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned BIT_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hamming_tx_arbiter_if.slave  bus
);

  localparam int unsigned DIV_W = 4;
  localparam int unsigned BIT_W = 3;
  localparam int unsigned PAD_W = MAX_REQ * DATA_W;

  state_t            state, state_n;
  logic [CW_W-1:0]   sr, sr_n;
  logic [BIT_W-1:0]  bitcnt, bitcnt_n;
  logic [DIV_W-1:0]  divcnt, divcnt_n;
  logic [IDX_W-1:0]  last_grant, last_grant_n;
  logic [IDX_W-1:0]  tx_owner_q, tx_owner_n;
  logic              tx_bit_q, tx_bit_n;
  logic              tx_frame_q, tx_frame_n;
  logic              busy_q, busy_n;

  logic [MAX_REQ-1:0] valid_pad;
  logic [PAD_W-1:0]   data_pad;
  logic               any_valid_c;
  logic [IDX_W-1:0]   grant_c;
  logic [NREQ-1:0]    ready_c;
  logic [DATA_W-1:0]  enc_in;
  logic [CW_W-1:0]    enc_cw_c;
  logic [CW_W-1:0]    cap_cw_c;

  // First valid requester after last_grant, wrapping modulo NREQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] v,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] g;
    logic             found;
    int unsigned      idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last) + k) % NREQ;
      if (!found && v[IDX_W'(idx)]) begin
        g     = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return g;
  endfunction

  // Grant selection and encoder input mux.
  always_comb begin
    valid_pad   = MAX_REQ'(bus.req_valid);
    data_pad    = PAD_W'(bus.req_data);
    any_valid_c = |bus.req_valid;
    grant_c     = rr_pick(valid_pad, last_grant);
    enc_in      = data_pad[{grant_c, 2'b00} +: DATA_W];
  end

  hamming_encoder u_enc (
    .data   (enc_in),
    .code_c (enc_cw_c)
  );

`ifdef ERR_INJECT_EN
  // Optional single-bit corruption of the captured codeword.
  always_comb begin
    cap_cw_c = enc_cw_c;
    if (bus.err_pos != 3'd0) begin
      cap_cw_c[bus.err_pos - 3'd1] = ~enc_cw_c[bus.err_pos - 3'd1];
    end
  end
`else
  assign cap_cw_c = enc_cw_c;
`endif

  // Ready is offered only in IDLE; gated by rst_n so it reads 0 during reset.
  always_comb begin
    ready_c = '0;
    if (state == IDLE && rst_n && any_valid_c) begin
      ready_c = NREQ'(1) << grant_c;
    end
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_n      = state;
    sr_n         = sr;
    bitcnt_n     = bitcnt;
    divcnt_n     = divcnt;
    last_grant_n = last_grant;
    tx_owner_n   = tx_owner_q;

    unique case (state)
      IDLE: begin
        if (any_valid_c) begin
          sr_n         = cap_cw_c;
          tx_owner_n   = grant_c;
          last_grant_n = grant_c;
          bitcnt_n     = '0;
          divcnt_n     = '0;
          state_n      = SHIFT;
        end
      end
      SHIFT: begin
        if (divcnt == DIV_W'(BIT_DIV - 1)) begin
          divcnt_n = '0;
          sr_n     = sr >> 1;
          bitcnt_n = bitcnt + 1'b1;
          if (bitcnt == BIT_W'(CW_W - 1)) begin
            state_n = GAP;
          end
        end else begin
          divcnt_n = divcnt + 1'b1;
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Outputs are registered from the next-state view so tx_bit shows sr[0]
    // in exactly the cycles the FSM sits in SHIFT.
    tx_frame_n = (state_n == SHIFT);
    tx_bit_n   = tx_frame_n & sr_n[0];
    busy_n     = (state_n != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sr         <= '0;
      bitcnt     <= '0;
      divcnt     <= '0;
      last_grant <= IDX_W'(NREQ - 1);
      tx_owner_q <= '0;
      tx_bit_q   <= 1'b0;
      tx_frame_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      bitcnt     <= bitcnt_n;
      divcnt     <= divcnt_n;
      last_grant <= last_grant_n;
      tx_owner_q <= tx_owner_n;
      tx_bit_q   <= tx_bit_n;
      tx_frame_q <= tx_frame_n;
      busy_q     <= busy_n;
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.tx_bit    = tx_bit_q;
  assign bus.tx_frame  = tx_frame_q;
  assign bus.tx_owner  = tx_owner_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_hamming_tx_arbiter.sv
// Bench for hamming_tx_arbiter: one instance with NREQ=2/BIT_DIV=1 and one
// with NREQ=3/BIT_DIV=3, exercised one at a time (sel_b) against a
// position-based Hamming model and a round-robin grant model.
module tb_hamming_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel_b;
  logic [3:0] valid;
  logic [3:0] data [4];
  logic [2:0] err;

  int total = 0;
  int bad   = 0;
  int last;
  int nreq;
  int div;

  always #5 clk = ~clk;

  hamming_tx_arbiter_if #(.NREQ(2)) bus_a ();
  hamming_tx_arbiter_if #(.NREQ(3)) bus_b ();

  assign bus_a.req_valid = sel_b ? 2'b00 : valid[1:0];
  assign bus_a.req_data  = {data[1], data[0]};
  assign bus_b.req_valid = sel_b ? valid[2:0] : 3'b000;
  assign bus_b.req_data  = {data[2], data[1], data[0]};
`ifdef ERR_INJECT_EN
  assign bus_a.err_pos = err;
  assign bus_b.err_pos = err;
`endif

  hamming_tx_arbiter #(.NREQ(2), .BIT_DIV(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  hamming_tx_arbiter #(.NREQ(3), .BIT_DIV(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  logic [3:0] o_ready;
  logic       o_bit, o_frame, o_busy;
  logic [1:0] o_owner;

  assign o_ready = sel_b ? {1'b0, bus_b.req_ready} : {2'b00, bus_a.req_ready};
  assign o_bit   = sel_b ? bus_b.tx_bit   : bus_a.tx_bit;
  assign o_frame = sel_b ? bus_b.tx_frame : bus_a.tx_frame;
  assign o_busy  = sel_b ? bus_b.busy     : bus_a.busy;
  assign o_owner = sel_b ? bus_b.tx_owner : bus_a.tx_owner;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Codeword by bit position 1..7: data at 3,5,6,7; parity p at 1,2,4
  // covers every position whose index has bit p set.
  function automatic logic [6:0] enc_model(input logic [3:0] d);
    logic [7:1] w;
    int         dpos [4];
    logic       par;
    dpos = '{3, 5, 6, 7};
    w    = '0;
    for (int i = 0; i < 4; i++) w[dpos[i]] = d[i];
    for (int p = 1; p <= 4; p = p * 2) begin
      par = 1'b0;
      for (int pos = 1; pos <= 7; pos++)
        if ((pos & p) != 0 && pos != p) par = par ^ w[pos];
      w[p] = par;
    end
    return w[7:1];
  endfunction

  function automatic int rr_model(input logic [3:0] v, input int lst, input int n);
    for (int k = 1; k <= n; k++) begin
      int i;
      i = (lst + k) % n;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [6:0] expect_cw(input logic [3:0] d);
    logic [6:0] cw;
    cw = enc_model(d);
    if (err != 3'd0) cw[err - 3'd1] = ~cw[err - 3'd1];
    return cw;
  endfunction

  function automatic logic [3:0] pending();
    return valid & 4'((1 << nreq) - 1);
  endfunction

  // Called just after a negedge with the DUT in IDLE.
  task automatic run_frame(input bit keep, input int raise, input bit rnd);
    int         g;
    int         b;
    logic [6:0] cw;
    #1;
    g = rr_model(valid, last, nreq);
    if (g < 0) begin
      chk("ready_none", o_ready, 16'h0);
      @(negedge clk);
      return;
    end
    chk("grant", o_ready, 16'(1 << g));
    chk("busy_idle", o_busy, 16'h0);
    cw = expect_cw(data[g]);
    @(posedge clk);
    #1;
    last = g;
    if (!keep) valid[g] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < div; j++) begin
        @(negedge clk);
        if (raise >= 0 && k == 1 && j == 0 && !valid[raise]) begin
          valid[raise] = 1'b1;
          data[raise]  = 4'($urandom);
        end
        if (rnd && $urandom_range(0, 3) == 0) begin
          b = $urandom_range(0, nreq - 1);
          if (!valid[b]) begin
            valid[b] = 1'b1;
            data[b]  = 4'($urandom);
          end
        end
        #1;
        chk("tx_bit", o_bit, cw[k]);
        chk("tx_frame", o_frame, 16'h1);
        chk("tx_owner", o_owner, 16'(g));
        chk("busy_shift", o_busy, 16'h1);
        chk("ready_shift", o_ready, 16'h0);
      end
    end
    @(negedge clk);
    #1;
    chk("gap_frame", o_frame, 16'h0);
    chk("gap_bit", o_bit, 16'h0);
    chk("gap_busy", o_busy, 16'h1);
    chk("gap_ready", o_ready, 16'h0);
    @(negedge clk);
    #1;
    chk("idle_frame", o_frame, 16'h0);
    chk("idle_busy", o_busy, 16'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_frame"}, o_frame, 16'h0);
    chk({tag, "_bit"}, o_bit, 16'h0);
    chk({tag, "_busy"}, o_busy, 16'h0);
    chk({tag, "_ready"}, o_ready, 16'h0);
    chk({tag, "_owner"}, o_owner, 16'h0);
  endtask

  // Start a frame, then assert rst_n during its 4th bit.
  task automatic reset_mid_frame();
    int         g;
    logic [6:0] cw;
    #1;
    g = rr_model(valid, last, nreq);
    chk("rm_grant", o_ready, 16'(1 << g));
    cw = expect_cw(data[g]);
    @(posedge clk);
    #1;
    last     = g;
    valid[g] = 1'b0;
    repeat (3 * div + 1) @(negedge clk);
    #1;
    chk("rm_bit3", o_bit, cw[3]);
    chk("rm_frame_before", o_frame, 16'h1);
    rst_n = 1'b0;
    valid = 4'b1111;
    #1;
    check_reset_outputs("rm_async");
    @(negedge clk);
    #1;
    check_reset_outputs("rm_hold");
    @(negedge clk);
    rst_n = 1'b1;
    last  = nreq - 1;
    run_frame(1'b0, -1, 1'b0);
  endtask

  task automatic random_step();
    if (pending() == 4'h0 && $urandom_range(0, 2) == 0) begin
      #1;
      chk("idle_ready", o_ready, 16'h0);
      chk("idle_busy0", o_busy, 16'h0);
      @(negedge clk);
      return;
    end
    if (pending() == 4'h0) begin
      for (int i = 0; i < nreq; i++) begin
        if ($urandom_range(0, 1) == 1 || i == nreq - 1) begin
          valid[i] = 1'b1;
          data[i]  = 4'($urandom);
        end
      end
    end
`ifdef ERR_INJECT_EN
    err = 3'($urandom_range(0, 7));
`endif
    run_frame(1'b0, -1, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sel_b = 1'b0;
    nreq  = 2;
    div   = 1;
    err   = 3'd0;
    valid = 4'h0;
    for (int i = 0; i < 4; i++) data[i] = 4'h0;
    rst_n = 1'b1;

    // Reset state, with requests present to confirm ready stays low.
    #2;
    rst_n = 1'b0;
    valid = 4'b0011;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    valid = 4'h0;
    rst_n = 1'b1;
    last  = nreq - 1;

    // Single requester, nibble 1011.
    valid   = 4'b0001;
    data[0] = 4'b1011;
    run_frame(1'b0, -1, 1'b0);

    // Both requesting continuously: grants alternate.
    data[0] = 4'h0;
    data[1] = 4'hF;
    valid   = 4'b0011;
    repeat (4) run_frame(1'b1, -1, 1'b0);
    valid = 4'h0;
    #1;
    chk("after_alt_ready", o_ready, 16'h0);
    @(negedge clk);

    // Requester 1 raises during SHIFT, served in the next frame.
    valid   = 4'b0001;
    data[0] = 4'($urandom);
    run_frame(1'b0, 1, 1'b0);
    run_frame(1'b0, -1, 1'b0);

    // Reset in mid-frame.
    valid   = 4'b0001;
    data[0] = 4'b0110;
    reset_mid_frame();

    repeat (40) random_step();

`ifdef ERR_INJECT_EN
    valid   = 4'h0;
    err     = 3'd3;
    @(negedge clk);
    valid   = 4'b0001;
    data[0] = 4'b1011;
    run_frame(1'b0, -1, 1'b0);
    err     = 3'd0;
    valid   = 4'b0001;
    data[0] = 4'b1011;
    run_frame(1'b0, -1, 1'b0);
`endif
    err = 3'd0;

    // Switch to the NREQ=3, BIT_DIV=3 instance from a clean reset.
    valid = 4'h0;
    @(negedge clk);
    sel_b = 1'b1;
    nreq  = 3;
    div   = 3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_b");
    @(negedge clk);
    rst_n = 1'b1;
    last  = nreq - 1;

    valid   = 4'b0001;
    data[0] = 4'b1011;
    run_frame(1'b0, -1, 1'b0);

    repeat (25) random_step();

    valid = 4'b0110;
    reset_mid_frame();

    repeat (10) random_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
